seg7_scan_rx: RTL and testbench

//   Receive-side monitor for the multiplexed seven-segment display bus. Samples the

---
 rtl/seg7_scan_rx.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_rx.sv
// Receive-side monitor for a multiplexed seven-segment bus: synchronise, wait for a settled
// pattern, decode it back to a hex nibble per digit. Optional error counter: SEG7RX_ERRCNT_EN.
module seg7_scan_rx #(
    parameter int unsigned NDIG        = 8,
    parameter int unsigned STABLE_CYC  = 4,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     an_i,
    input  logic                clr_i,
    output logic [4*NDIG-1:0]   digit_o,
    output logic [NDIG-1:0]     dig_vld_o,
    output logic                upd_o,
    output logic [2:0]          upd_idx_o,
    output logic [3:0]          upd_val_o,
    output logic                err_o,
    output logic [15:0]         err_cnt_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    localparam logic [3:0] STABLE = 4'(STABLE_CYC);

    // {legal, blank, nibble} for a lit-high gfedcba pattern
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h3F:   r = 6'b10_0000;
            7'h06:   r = 6'b10_0001;
            7'h5B:   r = 6'b10_0010;
            7'h4F:   r = 6'b10_0011;
            7'h66:   r = 6'b10_0100;
            7'h6D:   r = 6'b10_0101;
            7'h7D:   r = 6'b10_0110;
            7'h07:   r = 6'b10_0111;
            7'h7F:   r = 6'b10_1000;
            7'h6F:   r = 6'b10_1001;
            7'h77:   r = 6'b10_1010;
            7'h7C:   r = 6'b10_1011;
            7'h39:   r = 6'b10_1100;
            7'h5E:   r = 6'b10_1101;
            7'h79:   r = 6'b10_1110;
            7'h71:   r = 6'b10_1111;
            7'h00:   r = 6'b01_0000;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    logic [NDIG-1:0] an_s1, an_s2;
    logic [6:0]      seg_s1, seg_s2;
    logic [3:0]      cnt_q;
    state_e          state_q, state_d;

    // Anode sync flops reset to "no digit" so reset never looks like a multi-hot select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '0;
            seg_s2 <= '0;
        end else begin
            an_s1  <= an_i;
            an_s2  <= an_s1;
            seg_s1 <= seg_i;
            seg_s2 <= seg_s1;
        end
    end

    // s1 is the next value of s2, so this flags s2 taking a new value on this edge.
    logic changed;
    assign changed = {an_s1, seg_s1} != {an_s2, seg_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (changed) begin
            cnt_q <= '0;
        end else if (cnt_q != STABLE) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    logic [3:0] an_zeros;
    logic [2:0] an_idx;
    always_comb begin
        an_zeros = '0;
        an_idx   = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (!an_s2[k]) begin
                an_zeros = an_zeros + 4'd1;
                an_idx   = 3'(k);
            end
        end
    end

    logic [6:0] seg_lit;
    logic [5:0] dec;
    logic       dec_legal, dec_blank;
    logic [3:0] dec_nib;
    assign seg_lit   = SEG_ACT_LOW ? ~seg_s2 : seg_s2;
    assign dec       = decode(seg_lit);
    assign dec_legal = dec[5];
    assign dec_blank = dec[4];
    assign dec_nib   = dec[3:0];

    logic capture, one_hot, multi_hot, cap_upd, cap_err;
    assign capture   = (state_q == StSettle) && !changed && (cnt_q == STABLE);
    assign one_hot   = an_zeros == 4'd1;
    assign multi_hot = an_zeros >= 4'd2;
    assign cap_upd   = capture && one_hot && (dec_legal || dec_blank);
    assign cap_err   = capture && (multi_hot || (one_hot && !dec_legal && !dec_blank));

    always_comb begin
        state_d = state_q;
        if (changed) begin
            state_d = (&an_s1) ? StIdle : StSettle;
        end else begin
            case (state_q)
                StIdle:   if (!(&an_s2)) state_d = StSettle;
                StSettle: if (cnt_q == STABLE) state_d = StHold;
                StHold:   state_d = StHold;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    logic [4*NDIG-1:0] digit_d;
    logic [NDIG-1:0]   vld_d;
    logic              err_d;
    always_comb begin
        digit_d = digit_o;
        vld_d   = dig_vld_o;
        err_d   = err_o | cap_err;
        if (clr_i) begin
            digit_d = '0;
            vld_d   = '0;
            err_d   = 1'b0;
        end else if (cap_upd) begin
            for (int k = 0; k < NDIG; k++) begin
                if (an_idx == 3'(k)) begin
                    if (dec_legal) begin
                        digit_d[4*k +: 4] = dec_nib;
                        vld_d[k]          = 1'b1;
                    end else begin
                        vld_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_o   <= '0;
            dig_vld_o <= '0;
            upd_o     <= 1'b0;
            upd_idx_o <= '0;
            upd_val_o <= '0;
            err_o     <= 1'b0;
        end else begin
            digit_o   <= digit_d;
            dig_vld_o <= vld_d;
            err_o     <= err_d;
            upd_o     <= cap_upd;
            if (cap_upd) begin
                upd_idx_o <= an_idx;
                upd_val_o <= dec_legal ? dec_nib : 4'h0;
            end
        end
    end

`ifdef SEG7RX_ERRCNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (cap_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: decode table, hand-written corner sequences and random scans
// checked every cycle against a run-length model of the settle/capture rules.
module tb_seg7_scan_rx;

    localparam int NDIG   = 8;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_i = 7'h7F;
    logic [7:0]  an_i = 8'hFF;
    logic        clr_i = 1'b0;
    logic [31:0] digit_o;
    logic [7:0]  dig_vld_o;
    logic        upd_o;
    logic [2:0]  upd_idx_o;
    logic [3:0]  upd_val_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    seg7_scan_rx #(.NDIG(NDIG), .STABLE_CYC(STABLE), .SEG_ACT_LOW(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_i     (seg_i),
        .an_i      (an_i),
        .clr_i     (clr_i),
        .digit_o   (digit_o),
        .dig_vld_o (dig_vld_o),
        .upd_o     (upd_o),
        .upd_idx_o (upd_idx_o),
        .upd_val_o (upd_val_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [3:0]  m_digit [8];
    logic [7:0]  m_vld;
    logic        m_upd;
    logic [2:0]  m_idx;
    logic [3:0]  m_val;
    logic        m_err;
    int          m_cnt;
    logic [14:0] m_prev;
    int          m_run;
    bit          m_pend;
    logic [14:0] m_pend_pin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_digit[k] = 4'h0;
        m_vld = '0; m_upd = 0; m_idx = '0; m_val = '0; m_err = 0; m_cnt = 0;
        m_prev = '0; m_run = 0; m_pend = 0; m_pend_pin = '0;
    endtask

    task automatic model_err();
        m_err = 1'b1;
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Effect of a settled pin value {an, seg} (raw, active-low) on the outputs
    task automatic model_capture(input logic [14:0] p);
        logic [7:0] an;
        logic [6:0] lit;
        int zeros, k, nib;
        an = p[14:7];
        lit = ~p[6:0];
        zeros = 0;
        k = 0;
        for (int i = 0; i < NDIG; i++) if (!an[i]) begin zeros++; k = i; end
        if (zeros >= 2) begin
            model_err();
        end else if (zeros == 1) begin
            nib = -1;
            for (int v = 0; v < 16; v++) if (hex_pat[v] == lit) nib = v;
            if (nib >= 0) begin
                m_digit[k] = nib[3:0]; m_vld[k] = 1'b1;
                m_upd = 1'b1; m_idx = k[2:0]; m_val = nib[3:0];
            end else if (lit == 7'h00) begin
                m_vld[k] = 1'b0; m_upd = 1'b1; m_idx = k[2:0]; m_val = 4'h0;
            end else begin
                model_err();
            end
        end
    endtask

    // A pin value seen on STABLE+2 consecutive edges takes effect on the following edge.
    task automatic model_edge(input logic [7:0] an, input logic [6:0] seg, input logic clr);
        m_upd = 1'b0;
        if (m_pend) model_capture(m_pend_pin);
        m_pend = 0;
        if (clr) begin
            for (int k = 0; k < 8; k++) m_digit[k] = 4'h0;
            m_vld = '0; m_err = 0; m_cnt = 0;
        end
        if ({an, seg} == m_prev) m_run++;
        else m_run = 1;
        m_prev = {an, seg};
        if (m_run == STABLE + 2) begin m_pend = 1; m_pend_pin = {an, seg}; end
    endtask

    function automatic logic [31:0] m_digits();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = m_digit[k];
        return r;
    endfunction

    function automatic logic [15:0] m_errcnt();
`ifdef SEG7RX_ERRCNT_EN
        return 16'(m_cnt);
`else
        return 16'h0;
`endif
    endfunction

    task automatic compare_all();
        chk("digit_o", 64'(digit_o), 64'(m_digits()));
        chk("dig_vld_o", 64'(dig_vld_o), 64'(m_vld));
        chk("upd_o", 64'(upd_o), 64'(m_upd));
        chk("upd_idx_o", 64'(upd_idx_o), 64'(m_idx));
        chk("upd_val_o", 64'(upd_val_o), 64'(m_val));
        chk("err_o", 64'(err_o), 64'(m_err));
        chk("err_cnt_o", 64'(err_cnt_o), 64'(m_errcnt()));
    endtask

    // Called at a negedge: drive, clock, update model, compare at the next negedge.
    task automatic step(input logic [7:0] an, input logic [6:0] seg, input logic clr);
        an_i = an; seg_i = seg; clr_i = clr;
        @(posedge clk);
        model_edge(an, seg, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n,
                        output int upds, output logic [3:0] last);
        upds = 0;
        last = 4'h0;
        for (int i = 0; i < n; i++) begin
            step(an, seg, 1'b0);
            if (upd_o) begin upds++; last = upd_val_o; end
        end
    endtask

    function automatic logic [7:0] sel(input int k);
        logic [7:0] one = 8'h01;
        return ~(one << k);
    endfunction

    typedef struct {
        int         idx;
        logic [6:0] pat;
        int         exp_upd;
        logic [3:0] exp_val;
        logic       exp_vld;
        logic       exp_err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int upds, lat, a, b, r, nh;
        logic [3:0] last;
        logic [7:0] an;
        logic [6:0] lit;

        for (int i = 0; i < 16; i++)
            tbl[i] = '{idx: i % 8, pat: hex_pat[i], exp_upd: 1, exp_val: i[3:0],
                       exp_vld: 1'b1, exp_err: 1'b0};
        tbl[16] = '{idx: 2, pat: 7'h00, exp_upd: 1, exp_val: 4'h0, exp_vld: 1'b0, exp_err: 1'b0};
        tbl[17] = '{idx: 1, pat: 7'h01, exp_upd: 0, exp_val: 4'h0, exp_vld: 1'b0, exp_err: 1'b1};
        tbl[18] = '{idx: 5, pat: 7'h7E, exp_upd: 0, exp_val: 4'h0, exp_vld: 1'b0, exp_err: 1'b1};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_digit", 64'(digit_o), 64'h0);
        chk("reset_vld", 64'(dig_vld_o), 64'h0);
        chk("reset_err", 64'(err_o), 64'h0);
        chk("reset_upd", 64'(upd_o), 64'h0);
        rst_n = 1'b1;

        // Single digit: capture latency 2 + STABLE + 1
        lat = 0; upds = 0;
        for (int n = 1; n <= 10; n++) begin
            step(sel(0), ~7'h5B, 1'b0);
            if (upd_o) begin upds++; if (lat == 0) lat = n; end
        end
        chk("t1_latency", 64'(lat), 64'd7);
        chk("t1_upd_count", 64'(upds), 64'd1);
        chk("t1_idx", 64'(upd_idx_o), 64'd0);
        chk("t1_val", 64'(upd_val_o), 64'd2);
        chk("t1_digit", 64'(digit_o[3:0]), 64'd2);
        chk("t1_vld", 64'(dig_vld_o[0]), 64'd1);

        // Decode table
        foreach (tbl[i]) begin
            step(8'hFF, 7'h7F, 1'b1);
            hold(sel(tbl[i].idx), ~tbl[i].pat, 10, upds, last);
            chk("tbl_upd_count", 64'(upds), 64'(tbl[i].exp_upd));
            chk("tbl_val", 64'(last), 64'(tbl[i].exp_val));
            chk("tbl_digit", 64'(digit_o[4*tbl[i].idx +: 4]), 64'(tbl[i].exp_val));
            chk("tbl_vld", 64'(dig_vld_o[tbl[i].idx]), 64'(tbl[i].exp_vld));
            chk("tbl_err", 64'(err_o), 64'(tbl[i].exp_err));
        end

        // Full scan 0..7
        step(8'hFF, 7'h7F, 1'b1);
        nh = 0;
        for (int k = 0; k < 8; k++) begin
            hold(sel(k), ~hex_pat[k], 8, upds, last);
            nh += upds;
        end
        chk("t2_upd_count", 64'(nh), 64'd8);
        chk("t2_digits", 64'(digit_o), 64'h76543210);
        chk("t2_vld", 64'(dig_vld_o), 64'hFF);

        // Toggling faster than the settle window never captures
        nh = 0;
        for (int j = 0; j < 10; j++) begin
            hold(sel(3), (j % 2) ? ~hex_pat[1] : ~hex_pat[2], 3, upds, last);
            nh += upds;
        end
        chk("t3_upd_count", 64'(nh), 64'd0);
        chk("t3_digits", 64'(digit_o), 64'h76543210);

        // Illegal pattern on digit 1
        hold(sel(1), ~7'h01, 10, upds, last);
        chk("t4_err", 64'(err_o), 64'd1);
        chk("t4_upd_count", 64'(upds), 64'd0);
        chk("t4_vld1", 64'(dig_vld_o[1]), 64'd1);
        chk("t4_digit1", 64'(digit_o[7:4]), 64'd1);
`ifdef SEG7RX_ERRCNT_EN
        chk("t4_errcnt", 64'(err_cnt_o), 64'd1);
`else
        chk("t4_errcnt", 64'(err_cnt_o), 64'd0);
`endif
        step(8'hFF, 7'h7F, 1'b1);
        chk("t4_clr_err", 64'(err_o), 64'd0);
        chk("t4_clr_errcnt", 64'(err_cnt_o), 64'd0);

        // Multi-hot anode, then blank clears a valid digit
        hold(sel(2), ~hex_pat[5], 10, upds, last);
        chk("t5_vld2_set", 64'(dig_vld_o[2]), 64'd1);
        hold(~8'h03, ~hex_pat[4], 10, upds, last);
        chk("t5_multi_err", 64'(err_o), 64'd1);
        chk("t5_multi_upd", 64'(upds), 64'd0);
        hold(sel(2), 7'h7F, 10, upds, last);
        chk("t5_blank_upd", 64'(upds), 64'd1);
        chk("t5_blank_val", 64'(upd_val_o), 64'd0);
        chk("t5_vld2_clr", 64'(dig_vld_o[2]), 64'd0);
        chk("t5_digit2", 64'(digit_o[11:8]), 64'd5);

        // Reset in the middle of a settle
        hold(8'hFF, 7'h7F, 3, upds, last);
        for (int j = 0; j < 3; j++) step(sel(0), ~7'h5B, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_digit", 64'(digit_o), 64'h0);
        chk("t6_vld", 64'(dig_vld_o), 64'h0);
        chk("t6_upd", 64'(upd_o), 64'h0);
        chk("t6_idx", 64'(upd_idx_o), 64'h0);
        chk("t6_val", 64'(upd_val_o), 64'h0);
        chk("t6_err", 64'(err_o), 64'h0);
        chk("t6_errcnt", 64'(err_cnt_o), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step(sel(0), ~7'h5B, 1'b0);
            if (upd_o && lat == 0) lat = n;
        end
        chk("t6_latency", 64'(lat), 64'd7);

        // Random scans against the model
        for (int s = 0; s < 200; s++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            if (r == 0) an = 8'hFF;
            else if (r == 1) begin
                b = (a + 1 + $urandom_range(0, 6)) % 8;
                an = sel(a) & sel(b);
            end else an = sel(a);
            r = $urandom_range(0, 9);
            if (r == 0) lit = 7'h00;
            else if (r == 1) lit = 7'($urandom);
            else lit = hex_pat[$urandom_range(0, 15)];
            nh = $urandom_range(1, 10);
            for (int j = 0; j < nh; j++) step(an, ~lit, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
